// File: rtl/sig_bnc_gen_pkg.sv
// Shared types and constants for the bouncing-edge generator and its LFSR.
package sig_bnc_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHi,
        StLo,
        StSettle,
        StDone
    } bnc_state_e;

    localparam int unsigned LfsrWidth = 16;
    localparam logic [LfsrWidth-1:0] LfsrMask = 16'hB400;

    // Time base shared with the sig_deb receiver.
    localparam int unsigned DefClksPerSmpl = 16;

    // Galois right-shift step.
    function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LfsrMask : '0);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with a synchronous reload of its seed.
module lfsr16
    import sig_bnc_gen_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [LfsrWidth-1:0] o_val
);

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr16: an all-zero seed locks the LFSR");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_val <= SEED;
        end else begin
            o_val <= lfsr_next(o_val);
        end
    end

endmodule

// File: rtl/sig_bnc_gen.sv
// Produces a reproducible bouncing switch edge on o_sig on request, then holds the
// target level for a full settle time before pulsing o_done.
module sig_bnc_gen
    import sig_bnc_gen_pkg::*;
#(
    parameter int unsigned   CLKS_PER_SMPL = DefClksPerSmpl,
    parameter int unsigned   MAX_BNC       = 6,
    parameter int unsigned   GLITCH_MAX    = 8,
    parameter int unsigned   SETTLE_SMPL   = 8,
    parameter logic [15:0]   LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req,
    input  logic       i_lvl,
    output logic       o_sig,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_bnc_cnt
);

    localparam int unsigned SettleClks = SETTLE_SMPL * CLKS_PER_SMPL;
    localparam int unsigned CntSpan    = (SettleClks > 16) ? SettleClks : 16;
    localparam int unsigned CntW       = $clog2(CntSpan);

    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleClks - 1);
    localparam logic [3:0]      GlitchMask = 4'(GLITCH_MAX - 1);
    localparam logic [3:0]      MaxBnc     = 4'(MAX_BNC);

    if (CLKS_PER_SMPL < 1 || SETTLE_SMPL < 1) begin : g_bad_time
        $error("sig_bnc_gen: CLKS_PER_SMPL and SETTLE_SMPL must be >= 1");
    end
    if (MAX_BNC > 15) begin : g_bad_bnc
        $error("sig_bnc_gen: MAX_BNC must be <= 15");
    end
    if (GLITCH_MAX < 1 || GLITCH_MAX > 16 || (GLITCH_MAX & (GLITCH_MAX - 1)) != 0)
    begin : g_bad_glitch
        $error("sig_bnc_gen: GLITCH_MAX must be a power of 2 no larger than 16");
    end

    logic [LfsrWidth-1:0] r;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .o_val (r)
    );

    logic unused_r;
    assign unused_r = ^r[LfsrWidth-1:8];

    bnc_state_e      state;
    logic            tgt;
    logic [3:0]      n;
    logic [CntW-1:0] cnt;
    logic [3:0]      n_pick;
    logic [CntW-1:0] w_load;

    // Counters hold (width - 1), so a phase lasts exactly w clocks.
    always_comb begin
        n_pick = (r[3:0] > MaxBnc) ? MaxBnc : r[3:0];
        w_load = CntW'(r[7:4] & GlitchMask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            tgt       <= 1'b0;
            n         <= '0;
            cnt       <= '0;
            o_sig     <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_bnc_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (i_req) begin
                        tgt    <= i_lvl;
                        o_sig  <= i_lvl;
                        o_busy <= 1'b1;
                        if (i_lvl == o_sig || n_pick == 4'd0) begin
                            n         <= '0;
                            o_bnc_cnt <= '0;
                            cnt       <= SettleLoad;
                            state     <= StSettle;
                        end else begin
                            n         <= n_pick;
                            o_bnc_cnt <= n_pick;
                            cnt       <= w_load;
                            state     <= StHi;
                        end
                    end
                end
                StHi: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else begin
                        o_sig <= ~tgt;
                        cnt   <= w_load;
                        state <= StLo;
                    end
                end
                StLo: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else begin
                        o_sig <= tgt;
                        n     <= n - 4'd1;
                        if (n == 4'd1) begin
                            cnt   <= SettleLoad;
                            state <= StSettle;
                        end else begin
                            cnt   <= w_load;
                            state <= StHi;
                        end
                    end
                end
                StSettle: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else begin
                        o_done <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    o_busy <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_bnc_gen.sv
// Scoreboard bench for sig_bnc_gen: a timeline model predicts every o_sig edge and the
// o_done cycle of each request; a monitor pops and compares them as they occur.
module tb_sig_bnc_gen;

    localparam int          MaxBnc    = 6;
    localparam int          GlitchMax = 8;
    localparam int          SettleCyc = 16 * 8;
    localparam logic [15:0] Seed      = 16'hACE1;

    typedef struct {
        int   at;
        logic val;
    } edge_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_req, i_lvl;
    logic       o_sig, o_busy, o_done;
    logic [3:0] o_bnc_cnt;
    logic       req0, lvl0;
    logic       sig0, busy0, done0;
    logic [3:0] bnc0;

    int          cyc = 0;
    logic [15:0] m_lfsr = Seed;
    logic        exp_sig = 1'b0;
    logic        prev_sig = 1'b0;
    edge_t       eq[$];
    int          dq[$];
    edge_t       mon_e;
    int          n_vec = 0;
    int          n_err = 0;

    sig_bnc_gen u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_lvl     (i_lvl),
        .o_sig     (o_sig),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_bnc_cnt (o_bnc_cnt)
    );

    sig_bnc_gen #(
        .MAX_BNC (0)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req0),
        .i_lvl     (lvl0),
        .o_sig     (sig0),
        .o_busy    (busy0),
        .o_done    (done0),
        .o_bnc_cnt (bnc0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter and reference LFSR track the DUT edge for edge.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst_n ? lfsr_step(m_lfsr) : Seed;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_sig !== prev_sig) begin
                if (eq.size() == 0) begin
                    check_val("unexpected_edge", 32'(o_sig), 32'(prev_sig));
                end else begin
                    mon_e = eq.pop_front();
                    check_val("edge_cycle", 32'(cyc), 32'(mon_e.at));
                    check_val("edge_level", 32'(o_sig), 32'(mon_e.val));
                end
            end
            if (o_done === 1'b1) begin
                if (dq.size() == 0) check_val("unexpected_done", 32'(o_done), 32'd0);
                else check_val("done_cycle", 32'(cyc), 32'(dq.pop_front()));
            end
        end
        prev_sig = o_sig;
    end

    // Expand one accepted request (accept edge a, LFSR value r0) into its edge timeline.
    task automatic predict(input int a, input logic [15:0] r0, input logic lvl,
                           output int n_out, output int done_at);
        logic [15:0] rr;
        int          t;
        int          w;
        rr = r0;
        t  = 0;
        if (lvl == exp_sig) n_out = 0;
        else n_out = (int'(r0[3:0]) > MaxBnc) ? MaxBnc : int'(r0[3:0]);
        if (lvl != exp_sig) eq.push_back('{at: a, val: lvl});
        for (int i = 0; i < n_out; i++) begin
            w = 1 + int'(rr[7:4] & 4'(GlitchMax - 1));
            for (int k = 0; k < w; k++) rr = lfsr_step(rr);
            t += w;
            eq.push_back('{at: a + t, val: ~lvl});
            w = 1 + int'(rr[7:4] & 4'(GlitchMax - 1));
            for (int k = 0; k < w; k++) rr = lfsr_step(rr);
            t += w;
            eq.push_back('{at: a + t, val: lvl});
        end
        done_at = a + t + SettleCyc;
        dq.push_back(done_at);
        exp_sig = lvl;
    endtask

    task automatic start_req(input logic lvl, input logic hold, output int a, output int n_exp,
                             output int done_at, output logic [15:0] r0);
        @(negedge clk);
        i_req = 1'b1;
        i_lvl = lvl;
        a     = cyc + 1;
        r0    = m_lfsr;
        predict(a, r0, lvl, n_exp, done_at);
        @(negedge clk);
        if (!hold) i_req = 1'b0;
        check_val("accept_busy", 32'(o_busy), 32'd1);
        check_val("bnc_cnt", 32'(o_bnc_cnt), 32'(n_exp));
        check_val("bnc_le_max", 32'(int'(o_bnc_cnt) <= MaxBnc), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (o_busy !== 1'b0) check_val("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          a, n, d, a2, n2, d2, k, edges, first, dcyc, bcyc;
        logic [15:0] r0, r2;
        logic        lvl, pr, got_lo;

        rst_n = 1'b0;
        i_req = 1'b1;
        i_lvl = 1'b1;
        req0  = 1'b1;
        lvl0  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sig", 32'(o_sig), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_done", 32'(o_done), 32'd0);
        check_val("rst_bnc", 32'(o_bnc_cnt), 32'd0);
        check_val("rst_sig0", 32'(sig0), 32'd0);
        check_val("rst_busy0", 32'(busy0), 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        req0  = 1'b0;
        rst_n = 1'b1;

        // Clean-edge instance: one edge, done after the settle time, busy drops a cycle later.
        @(negedge clk);
        req0 = 1'b1;
        lvl0 = 1'b1;
        a    = cyc + 1;
        @(negedge clk);
        req0  = 1'b0;
        edges = 0;
        first = -1;
        dcyc  = -1;
        bcyc  = -1;
        pr    = 1'b0;
        for (int i = 0; i < 140; i++) begin
            if (sig0 !== pr) begin
                edges++;
                if (first < 0) first = cyc;
            end
            if (done0 === 1'b1 && dcyc < 0) dcyc = cyc;
            if (dcyc >= 0 && busy0 === 1'b0 && bcyc < 0) bcyc = cyc;
            pr = sig0;
            @(negedge clk);
        end
        check_val("clean_edges", 32'(edges), 32'd1);
        check_val("clean_first_edge", 32'(first), 32'(a));
        check_val("clean_done", 32'(dcyc), 32'(a + SettleCyc));
        check_val("clean_busy_low", 32'(bcyc), 32'(a + SettleCyc + 1));
        check_val("clean_bnc", 32'(bnc0), 32'd0);
        check_val("clean_level", 32'(sig0), 32'd1);

        // Alternating random-gap requests; some get busy/DONE-cycle pokes that must be ignored.
        lvl = 1'b1;
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_req(lvl, 1'b0, a, n, d, r0);
            if (i % 10 == 4) begin
                @(negedge clk);
                i_req = 1'b1;
                i_lvl = ~lvl;
                @(negedge clk);
                i_req = 1'b0;
                k = 0;
                while (o_done !== 1'b1 && k < 3000) begin
                    @(negedge clk);
                    k++;
                end
                i_req = 1'b1;
                i_lvl = ~lvl;
                @(negedge clk);
                i_req = 1'b0;
            end
            wait_idle();
            check_val("final_level", 32'(o_sig), 32'(lvl));
            lvl = ~lvl;
        end

        // Same-level request: no edge, still settles and completes.
        start_req(exp_sig, 1'b0, a, n, d, r0);
        wait_idle();

        // Held request: first completes, then retriggers on the first IDLE cycle.
        start_req(~exp_sig, 1'b1, a, n, d, r0);
        a2 = d + 2;
        r2 = r0;
        for (int i = 0; i < a2 - a; i++) r2 = lfsr_step(r2);
        predict(a2, r2, exp_sig, n2, d2);
        k = 0;
        while (cyc < a2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        i_req = 1'b0;
        check_val("held_busy", 32'(o_busy), 32'd1);
        check_val("held_bnc", 32'(o_bnc_cnt), 32'(n2));
        wait_idle();

        // Reset during a LO glitch aborts at once with no completion.
        got_lo = 1'b0;
        for (int t = 0; t < 10 && !got_lo; t++) begin
            if (exp_sig) begin
                start_req(1'b0, 1'b0, a, n, d, r0);
                wait_idle();
            end
            start_req(1'b1, 1'b0, a, n, d, r0);
            if (n > 0) begin
                k = 0;
                while (!(cyc > a && o_sig === 1'b0) && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                got_lo = (o_sig === 1'b0);
                rst_n  = 1'b0;
                @(posedge clk);
                #1;
                check_val("abort_sig", 32'(o_sig), 32'd0);
                check_val("abort_busy", 32'(o_busy), 32'd0);
                check_val("abort_bnc", 32'(o_bnc_cnt), 32'd0);
                @(negedge clk);
                eq.delete();
                dq.delete();
                exp_sig = 1'b0;
                rst_n   = 1'b1;
            end else begin
                wait_idle();
            end
        end
        check_val("reached_lo", 32'(got_lo), 32'd1);
        repeat (300) @(negedge clk);
        check_val("post_abort_busy", 32'(o_busy), 32'd0);
        check_val("post_abort_sig", 32'(o_sig), 32'd0);
        check_val("edges_left", 32'(eq.size()), 32'd0);
        check_val("dones_left", 32'(dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
